serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Parametrised single-clock serial frame receiver. It is the successor to the fixed 8N1 byte receiver used in the FSM/serial-data family of blocks. The line is sampled one bit per clock (no oversampling). The block adds configurable data width, optional odd or even parity, one or two stop bits, error recovery, and a valid/ready output holding register with overrun detection. It sits between a synchronised serial input and a byte-stream consumer.

## Interface
Parameters:
- DATA_W, default 8: data bits per frame, legal range 5..16.
- PARITY_EN, default 0: 1 means a parity bit follows the data bits.
- PARITY_ODD, default 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.
- STOP_BITS, default 1: number of stop bits, 1 or 2.

Ports:
- clk, input, 1: sole clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-high.
- in, input, 1: serial line. Idle level is 1. Already synchronous to clk.
- out_data, output, DATA_W: received data, LSB received first.
- out_valid, output, 1: out_data holds an unconsumed frame.
- out_ready, input, 1: consumer accepts out_data when out_valid && out_ready.
- parity_err, output, 1: qualifies out_data. High means the held frame failed parity. Always 0 when PARITY_EN=0.
- frame_err, output, 1: one-cycle pulse when a stop bit is sampled as 0.
- overrun, output, 1: one-cycle pulse when a good frame is dropped because the holding register is full.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP, ERR.
- IDLE: if in=0, this cycle is the start bit; go to DATA and clear the bit counter. If in=1, stay in IDLE.
- DATA: shift in into bit position cnt; cnt increments each cycle. After DATA_W bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: sample the parity bit. The bit is good when the XOR of the data bits and the parity bit equals PARITY_ODD. Go to STOP.
- STOP: sample STOP_BITS bits. Any stop bit sampled as 0:
  - pulse frame_err the next cycle;
  - discard the frame;
  - go to ERR immediately, without sampling a remaining second stop bit.
- STOP, all stop bits 1: the frame completes on the final stop-bit cycle. Go to IDLE.
- ERR: stay while in=0. Go to IDLE on the first cycle with in=1. That 1 is consumed as idle, not treated as a start bit.
- Completion with out_valid=0, or with out_valid=1 && out_ready=1 in the same cycle:
  - load out_data and parity_err;
  - out_valid=1 the next cycle.
- Completion with out_valid=1 && out_ready=0:
  - keep the held frame unchanged;
  - pulse overrun the next cycle.
- Handshake without a completion: out_valid clears the next cycle. out_data and parity_err hold their last values.
- out_valid stays high with stable out_data and parity_err until accepted.
- A frame with a parity error but good stop bits is still delivered, with parity_err=1. It is not a frame_err.

## Timing
- Reset (asynchronous): state=IDLE, cnt=0, out_data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0. Reset mid-frame aborts the frame with no error pulse.
- Frame length: 1 + DATA_W + PARITY_EN + STOP_BITS cycles.
- out_valid rises on the cycle after the final stop bit is sampled.
- Back-to-back frames: the start bit of the next frame may arrive on the cycle immediately after the final stop bit. No idle cycle is required.
- frame_err and overrun are registered single-cycle pulses, asserted the cycle after the triggering sample.
- out_ready has no combinational path to any output.

## Test plan
- DATA_W=8, no parity, 1 stop. Send 0xA5: 0, then 1,0,1,0,0,1,0,1, then 1. Required: out_valid the cycle after the stop bit, out_data=0xA5, parity_err=0.
- Back-to-back frames 0x3C then 0xC3 with no idle between, out_ready=1. Required: two out_valid cycles exactly 10 cycles apart, carrying 0x3C then 0xC3.
- PARITY_EN=1, even parity. Send 0x07 with parity bit 1, then 0x07 with parity bit 0. Required: first frame parity_err=0, second parity_err=1, both delivered.
- Stop bit 0 on 0x55, line held 0 for 3 cycles, then 1, then a valid 0x12. Required: one frame_err pulse, no out_valid for 0x55, then 0x12 delivered normally.
- out_ready=0, send 0x11 then 0x22. Required: out_data stays 0x11; one overrun pulse the cycle after 0x22's stop bit; raising out_ready then clears out_valid.
- STOP_BITS=2, DATA_W=5. Send 0x1F with second stop bit 0. Required: frame_err pulse, no delivery. Also assert reset mid-data; required: all outputs 0 and the FSM in IDLE.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits (LSB first), optional parity, 1-2 stop bits.
// Latency: out_valid rises the cycle after the final stop bit is sampled; one line bit per clock.
// Backpressure: one-deep holding register; a good frame arriving while it is full is dropped and flagged.
//
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   in              - serial line, idle high, already synchronous to clk
//   out_data        - received data word
//   out_valid       - out_data holds an unconsumed frame
//   out_ready       - consumer accepts out_data when out_valid && out_ready
//   parity_err      - qualifies out_data: held frame failed its parity check
//   frame_err       - one-cycle pulse after a stop bit was sampled as 0
//   overrun         - one-cycle pulse after a good frame was dropped (holding register full)
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    // Wide enough for DATA_W up to 16; also reused to count stop bits.
    localparam int   CNT_W     = 5;
    localparam logic PAR_ODD_B = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bad;
    logic              done;
    logic              stop_fail;
    logic              data_last;
    logic              stop_last;

    assign data_last = (cnt == CNT_W'(DATA_W - 1));
    assign stop_last = (cnt == CNT_W'(STOP_BITS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        stop_fail = 1'b0;
        case (state)
            IDLE: begin
                if (!in) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (data_last) begin
                    if (PARITY_EN != 0) begin
                        state_nxt = PARITY;
                    end else begin
                        state_nxt = STOP;
                    end
                end
            end
            PARITY: begin
                state_nxt = STOP;
            end
            STOP: begin
                // A bad first stop bit aborts at once; the second one is never looked at.
                if (!in) begin
                    stop_fail = 1'b1;
                    state_nxt = ERR;
                end else if (stop_last) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                // The first 1 seen here is swallowed as idle, never taken as a start bit.
                if (in) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit counter, data shift register and parity verdict for the frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    par_bad <= 1'b0;
                end
                DATA: begin
                    // Shift right so the first (LSB) bit lands at position 0 after DATA_W bits.
                    shreg <= {in, shreg[DATA_W-1:1]};
                    if (data_last) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    par_bad <= ((^shreg) ^ in) != PAR_ODD_B;
                end
                STOP: begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Holding register and registered error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_fail;
            overrun   <= done && out_valid && !out_ready;
            if (done && (!out_valid || out_ready)) begin
                out_data   <= shreg;
                parity_err <= par_bad;
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       out_ready;
    logic       in_a, in_p, in_s;
    logic [7:0] a_dat, p_dat;
    logic [4:0] s_dat;
    logic       a_vld, a_perr, a_ferr, a_ovr;
    logic       p_vld, p_perr, p_ferr, p_ovr;
    logic       s_vld, s_perr, s_ferr, s_ovr;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int a_vld_n, a_fe_n, a_ov_n, s_vld_n, s_fe_n;
    int a_vcyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_vld) begin a_vld_n++; a_vcyc.push_back(cyc); end
        if (a_ferr) a_fe_n++;
        if (a_ovr) a_ov_n++;
        if (s_vld) s_vld_n++;
        if (s_ferr) s_fe_n++;
    end

    // 8N1
    serial_frame_rx u_a (
        .clk(clk), .reset(reset), .in(in_a), .out_data(a_dat), .out_valid(a_vld),
        .out_ready(out_ready), .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr)
    );
    // 8 data, even parity, 1 stop
    serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_p (
        .clk(clk), .reset(reset), .in(in_p), .out_data(p_dat), .out_valid(p_vld),
        .out_ready(out_ready), .parity_err(p_perr), .frame_err(p_ferr), .overrun(p_ovr)
    );
    // 5 data, no parity, 2 stop
    serial_frame_rx #(.DATA_W(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_s (
        .clk(clk), .reset(reset), .in(in_s), .out_data(s_dat), .out_valid(s_vld),
        .out_ready(out_ready), .parity_err(s_perr), .frame_err(s_ferr), .overrun(s_ovr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] d, input logic stp);
        in_a = 1'b0; step();
        for (int i = 0; i < 8; i++) begin in_a = d[i]; step(); end
        in_a = stp; step();
        in_a = 1'b1;
    endtask

    task automatic send_p(input logic [7:0] d, input logic par, input logic stp);
        in_p = 1'b0; step();
        for (int i = 0; i < 8; i++) begin in_p = d[i]; step(); end
        in_p = par; step();
        in_p = stp; step();
        in_p = 1'b1;
    endtask

    task automatic send_s(input logic [4:0] d, input logic s1, input logic s2);
        in_s = 1'b0; step();
        for (int i = 0; i < 5; i++) begin in_s = d[i]; step(); end
        in_s = s1; step();
        in_s = s2; step();
        in_s = 1'b1;
    endtask

    task automatic test_reset();
        n_vec++; if (a_dat !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", a_dat); end
        n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", a_vld); end
        n_vec++; if (a_perr !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", a_perr); end
        n_vec++; if (a_ferr !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b want 0", a_ferr); end
        n_vec++; if (a_ovr !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b want 0", a_ovr); end
    endtask

    task automatic test_basic();
        logic [9:0] v;
        v = {1'b1, 8'hA5, 1'b0};
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", a_vld); end
            end
            in_a = v[i]; step();
        end
        in_a = 1'b1;
        n_vec++; if (a_vld !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", a_vld); end
        n_vec++; if (a_dat !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", a_dat); end
        n_vec++; if (a_perr !== 1'b0) begin n_err++; $display("FAIL basic_perr: got %b want 0", a_perr); end
        out_ready = 1'b1; step();
        n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL basic_accept: got %b want 0", a_vld); end
        n_vec++; if (a_dat !== 8'hA5) begin n_err++; $display("FAIL basic_hold: got %h want a5", a_dat); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        a_vcyc.delete();
        send_a(8'h3C, 1'b1);
        n_vec++; if (a_dat !== 8'h3C) begin n_err++; $display("FAIL b2b_data0: got %h want 3c", a_dat); end
        send_a(8'hC3, 1'b1);
        n_vec++; if (a_vld !== 1'b1) begin n_err++; $display("FAIL b2b_valid1: got %b want 1", a_vld); end
        n_vec++; if (a_dat !== 8'hC3) begin n_err++; $display("FAIL b2b_data1: got %h want c3", a_dat); end
        step(); step();
        n_vec++; if (a_vcyc.size() !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", a_vcyc.size()); end
        else begin
            n_vec++; if (a_vcyc[1] - a_vcyc[0] !== 10) begin n_err++; $display("FAIL b2b_spacing: got %0d want 10", a_vcyc[1] - a_vcyc[0]); end
        end
    endtask

    task automatic test_parity();
        out_ready = 1'b1;
        send_p(8'h07, 1'b1, 1'b1);
        n_vec++; if (p_vld !== 1'b1) begin n_err++; $display("FAIL par_valid0: got %b want 1", p_vld); end
        n_vec++; if (p_dat !== 8'h07) begin n_err++; $display("FAIL par_data0: got %h want 07", p_dat); end
        n_vec++; if (p_perr !== 1'b0) begin n_err++; $display("FAIL par_good: got %b want 0", p_perr); end
        send_p(8'h07, 1'b0, 1'b1);
        n_vec++; if (p_vld !== 1'b1) begin n_err++; $display("FAIL par_valid1: got %b want 1", p_vld); end
        n_vec++; if (p_perr !== 1'b1) begin n_err++; $display("FAIL par_bad: got %b want 1", p_perr); end
        n_vec++; if (p_ferr !== 1'b0) begin n_err++; $display("FAIL par_no_ferr: got %b want 0", p_ferr); end
        n_vec++; if (p_ovr !== 1'b0) begin n_err++; $display("FAIL par_no_ovr: got %b want 0", p_ovr); end
        step();
        n_vec++; if (p_vld !== 1'b0) begin n_err++; $display("FAIL par_accept: got %b want 0", p_vld); end
        n_vec++; if (p_perr !== 1'b1) begin n_err++; $display("FAIL par_perr_hold: got %b want 1", p_perr); end
    endtask

    task automatic test_frame_err();
        out_ready = 1'b1;
        a_vld_n = 0; a_fe_n = 0;
        send_a(8'h55, 1'b0);
        n_vec++; if (a_ferr !== 1'b1) begin n_err++; $display("FAIL ferr_pulse: got %b want 1", a_ferr); end
        n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL ferr_no_valid: got %b want 0", a_vld); end
        in_a = 1'b0; step();
        n_vec++; if (a_ferr !== 1'b0) begin n_err++; $display("FAIL ferr_single: got %b want 0", a_ferr); end
        step(); step();
        in_a = 1'b1; step();
        send_a(8'h12, 1'b1);
        n_vec++; if (a_vld !== 1'b1) begin n_err++; $display("FAIL ferr_recover_valid: got %b want 1", a_vld); end
        n_vec++; if (a_dat !== 8'h12) begin n_err++; $display("FAIL ferr_recover_data: got %h want 12", a_dat); end
        step();
        n_vec++; if (a_fe_n !== 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", a_fe_n); end
        n_vec++; if (a_vld_n !== 1) begin n_err++; $display("FAIL ferr_vld_count: got %0d want 1", a_vld_n); end
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        a_ov_n = 0;
        send_a(8'h11, 1'b1);
        n_vec++; if (a_dat !== 8'h11) begin n_err++; $display("FAIL ovr_first: got %h want 11", a_dat); end
        send_a(8'h22, 1'b1);
        n_vec++; if (a_ovr !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", a_ovr); end
        n_vec++; if (a_dat !== 8'h11) begin n_err++; $display("FAIL ovr_keep: got %h want 11", a_dat); end
        n_vec++; if (a_vld !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", a_vld); end
        step();
        n_vec++; if (a_ovr !== 1'b0) begin n_err++; $display("FAIL ovr_single: got %b want 0", a_ovr); end
        out_ready = 1'b1; step();
        n_vec++; if (a_vld !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got %b want 0", a_vld); end
        n_vec++; if (a_ov_n !== 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", a_ov_n); end
    endtask

    task automatic test_two_stop();
        out_ready = 1'b1;
        s_fe_n = 0;
        send_s(5'h0A, 1'b1, 1'b1);
        n_vec++; if (s_vld !== 1'b1) begin n_err++; $display("FAIL two_valid: got %b want 1", s_vld); end
        n_vec++; if (s_dat !== 5'h0A) begin n_err++; $display("FAIL two_data: got %h want 0a", s_dat); end
        send_s(5'h1F, 1'b1, 1'b0);
        n_vec++; if (s_ferr !== 1'b1) begin n_err++; $display("FAIL two_stop2_ferr: got %b want 1", s_ferr); end
        n_vec++; if (s_vld !== 1'b0) begin n_err++; $display("FAIL two_stop2_novalid: got %b want 0", s_vld); end
        n_vec++; if (s_dat !== 5'h0A) begin n_err++; $display("FAIL two_stop2_keep: got %h want 0a", s_dat); end
        step();
        s_vld_n = 0;
        // first stop bit bad: the following 1 is idle, next frame starts right after
        send_s(5'h03, 1'b0, 1'b1);
        send_s(5'h15, 1'b1, 1'b1);
        n_vec++; if (s_dat !== 5'h15) begin n_err++; $display("FAIL two_stop1_recover: got %h want 15", s_dat); end
        step();
        n_vec++; if (s_fe_n !== 2) begin n_err++; $display("FAIL two_ferr_count: got %0d want 2", s_fe_n); end
        n_vec++; if (s_vld_n !== 1) begin n_err++; $display("FAIL two_vld_count: got %0d want 1", s_vld_n); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        s_fe_n = 0;
        send_s(5'h0B, 1'b1, 1'b1);
        n_vec++; if (s_vld !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b want 1", s_vld); end
        in_s = 1'b0; step();
        in_s = 1'b1; step();
        in_s = 1'b0; step();
        reset = 1'b1; #1;
        n_vec++; if (s_vld !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", s_vld); end
        n_vec++; if (s_dat !== 5'h00) begin n_err++; $display("FAIL mid_data: got %h want 00", s_dat); end
        n_vec++; if (s_perr !== 1'b0) begin n_err++; $display("FAIL mid_perr: got %b want 0", s_perr); end
        n_vec++; if (s_ferr !== 1'b0) begin n_err++; $display("FAIL mid_ferr: got %b want 0", s_ferr); end
        n_vec++; if (s_ovr !== 1'b0) begin n_err++; $display("FAIL mid_ovr: got %b want 0", s_ovr); end
        in_s = 1'b1; step();
        reset = 1'b0;
        out_ready = 1'b1;
        send_s(5'h15, 1'b1, 1'b1);
        n_vec++; if (s_vld !== 1'b1) begin n_err++; $display("FAIL mid_after_valid: got %b want 1", s_vld); end
        n_vec++; if (s_dat !== 5'h15) begin n_err++; $display("FAIL mid_after_data: got %h want 15", s_dat); end
        step();
        n_vec++; if (s_fe_n !== 0) begin n_err++; $display("FAIL mid_no_ferr: got %0d want 0", s_fe_n); end
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        in_a = 1'b1; in_p = 1'b1; in_s = 1'b1;
        a_vld_n = 0; a_fe_n = 0; a_ov_n = 0; s_vld_n = 0; s_fe_n = 0;
        step(); step();
        test_reset();
        reset = 1'b0;
        step();
        test_basic();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_overrun();
        test_two_stop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
